// File: rtl/my_alu_pkg.sv
// my_alu_pkg: shared types and constants for the 16-bit PDP-11 compatible ALU.
// Provides the operation-select encoding, the one-hot strobe bundle, the signed
// boundary constants for word and byte width, and the PSW flag bit positions.
package my_alu_pkg;

   // Decoded operation, produced from the one-hot strobes by priority.
   typedef enum logic [4:0] {
      OP_NONE, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC2, OP_DEC2, OP_INC,
      OP_DEC, OP_CLR, OP_COM, OP_NEG, OP_TST, OP_ROR, OP_ROL, OP_ASR,
      OP_ASL, OP_SXT, OP_MOV, OP_CMP, OP_BIT, OP_BIC, OP_BIS, OP_EXOR,
      OP_SWAB
   } op_e;

   // Strobes in port order; add sits in the msb and has highest priority.
   typedef struct packed {
      logic add;  logic adc;  logic sub;  logic sbc;
      logic inc2; logic dec2; logic inc;  logic dec;
      logic clr;  logic com;  logic neg;  logic tst;
      logic ror;  logic rol;  logic asr;  logic asl;
      logic sxt;  logic mov;  logic cmp;  logic bit_;
      logic bic;  logic bis;  logic exor; logic swab;
   } op_strb_t;

   localparam logic [15:0] WORD_MOST_NEG = 16'h8000;
   localparam logic [15:0] WORD_MAX_POS  = 16'h7FFF;
   localparam logic [15:0] WORD_ONES     = 16'hFFFF;
   localparam logic [15:0] BYTE_MOST_NEG = 16'h0080;
   localparam logic [15:0] BYTE_MAX_POS  = 16'h007F;
   localparam logic [15:0] BYTE_ONES     = 16'h00FF;

   // Flag positions inside the {N,Z,V,C} nibble.
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_V = 1;
   localparam int FLG_C = 0;

   // First asserted strobe in port order wins.
   function automatic op_e sel_op(input op_strb_t s);
      op_e o;
      o = OP_NONE;
      if      (s.add)  o = OP_ADD;
      else if (s.adc)  o = OP_ADC;
      else if (s.sub)  o = OP_SUB;
      else if (s.sbc)  o = OP_SBC;
      else if (s.inc2) o = OP_INC2;
      else if (s.dec2) o = OP_DEC2;
      else if (s.inc)  o = OP_INC;
      else if (s.dec)  o = OP_DEC;
      else if (s.clr)  o = OP_CLR;
      else if (s.com)  o = OP_COM;
      else if (s.neg)  o = OP_NEG;
      else if (s.tst)  o = OP_TST;
      else if (s.ror)  o = OP_ROR;
      else if (s.rol)  o = OP_ROL;
      else if (s.asr)  o = OP_ASR;
      else if (s.asl)  o = OP_ASL;
      else if (s.sxt)  o = OP_SXT;
      else if (s.mov)  o = OP_MOV;
      else if (s.cmp)  o = OP_CMP;
      else if (s.bit_) o = OP_BIT;
      else if (s.bic)  o = OP_BIC;
      else if (s.bis)  o = OP_BIS;
      else if (s.exor) o = OP_EXOR;
      else if (s.swab) o = OP_SWAB;
      return o;
   endfunction

endpackage

// File: rtl/my_alu_if.sv
// my_alu_if: operand/strobe/result bundle between the datapath and my_alu.
// Ports: in1 (B), in2 (A), ni, ci, mbyte, 24 op strobes -> final_result,
// final_flags {N,Z,V,C}, ccmask {N,Z,V,C}. master = datapath, slave = ALU.
interface my_alu_if;
   logic [15:0] in1;
   logic [15:0] in2;
   logic        ni;
   logic        ci;
   logic        mbyte;
   logic add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst;
   logic ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab;
   logic [15:0] final_result;
   logic [3:0]  final_flags;
   logic [3:0]  ccmask;

   modport master (
      output in1, in2, ni, ci, mbyte,
             add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst,
             ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab,
      input  final_result, final_flags, ccmask
   );

   modport slave (
      input  in1, in2, ni, ci, mbyte,
             add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst,
             ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab,
      output final_result, final_flags, ccmask
   );
endinterface

// File: rtl/my_alu_core.sv
// alu_core: combinational PDP-11 ALU function (operands, strobes -> result/flags/mask).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; evaluated continuously, no handshake.
// Ports: in1 (B), in2 (A), ni, ci, mbyte, strb -> result, flags {N,Z,V,C}, mask.
module alu_core
   import my_alu_pkg::*;
(
   input  logic [15:0] in1,
   input  logic [15:0] in2,
   input  logic        ni,
   input  logic        ci,
   input  logic        mbyte,
   input  op_strb_t    strb,
   output logic [15:0] result,
   output logic [3:0]  flags,
   output logic [3:0]  mask
);

   op_e         op;
   logic        wide;
   logic [15:0] a;
   logic [15:0] b;
   logic [15:0] max_pos;
   logic [15:0] most_neg;
   logic [15:0] all_ones;
   logic [16:0] sum;
   logic [15:0] lo;
   logic        cout;
   logic        a_msb;
   logic        b_msb;
   logic        r_msb;
   logic        n, z, v, c;

   assign op   = sel_op(strb);
   // inc2/dec2/swab have no byte form and ignore mbyte.
   assign wide = ~mbyte | (op == OP_INC2) | (op == OP_DEC2) | (op == OP_SWAB);

   // Byte operands are zero-extended so the carry/borrow of the low byte
   // lands in sum[8] of the shared 17-bit arithmetic.
   assign a = wide ? in2 : {8'h00, in2[7:0]};
   assign b = wide ? in1 : {8'h00, in1[7:0]};

   assign max_pos  = wide ? WORD_MAX_POS  : BYTE_MAX_POS;
   assign most_neg = wide ? WORD_MOST_NEG : BYTE_MOST_NEG;
   assign all_ones = wide ? WORD_ONES     : BYTE_ONES;

   assign a_msb = wide ? a[15] : a[7];
   assign b_msb = wide ? b[15] : b[7];

   // Raw value of the selected operation; bits above the active width are
   // don't-care and get stripped into lo below.
   always_comb begin
      sum = '0;
      case (op)
         OP_ADD:  sum = {1'b0, a} + {1'b0, b};
         OP_ADC:  sum = {1'b0, a} + {16'h0000, ci};
         OP_SUB:  sum = {1'b0, a} - {1'b0, b};
         OP_SBC:  sum = {1'b0, a} - {16'h0000, ci};
         OP_CMP:  sum = {1'b0, b} - {1'b0, a};
         OP_INC2: sum = {1'b0, a} + 17'd2;
         OP_DEC2: sum = {1'b0, a} - 17'd2;
         OP_INC:  sum = {1'b0, a} + 17'd1;
         OP_DEC:  sum = {1'b0, a} - 17'd1;
         OP_CLR:  sum = '0;
         OP_COM:  sum = {1'b0, ~a};
         OP_NEG:  sum = 17'd0 - {1'b0, a};
         OP_TST:  sum = {1'b0, a};
         OP_MOV:  sum = {1'b0, a};
         OP_ROR:  sum = wide ? {1'b0, ci, a[15:1]}
                             : {9'h000, ci, a[7:1]};
         OP_ROL:  sum = wide ? {1'b0, a[14:0], ci}
                             : {9'h000, a[6:0], ci};
         OP_ASR:  sum = wide ? {1'b0, a[15], a[15:1]}
                             : {9'h000, a[7], a[7:1]};
         OP_ASL:  sum = wide ? {1'b0, a[14:0], 1'b0}
                             : {9'h000, a[6:0], 1'b0};
         OP_SXT:  sum = ni ? {1'b0, WORD_ONES} : 17'd0;
         OP_BIT:  sum = {1'b0, a & b};
         OP_BIC:  sum = {1'b0, a & ~b};
         OP_BIS:  sum = {1'b0, a | b};
         OP_EXOR: sum = {1'b0, a ^ b};
         OP_SWAB: sum = {1'b0, a[7:0], a[15:8]};
         default: sum = '0;
      endcase
   end

   assign lo    = wide ? sum[15:0] : {8'h00, sum[7:0]};
   assign cout  = wide ? sum[16] : sum[8];
   assign r_msb = wide ? lo[15] : lo[7];

   // Byte results keep the destination's high byte; idle cycles give zero.
   assign result = (op == OP_NONE) ? 16'h0000
                 : wide            ? lo
                 :                   {in2[15:8], lo[7:0]};

   always_comb begin
      n    = r_msb;
      z    = (lo == 16'h0000);
      v    = 1'b0;
      c    = 1'b0;
      mask = 4'b1111;
      case (op)
         OP_ADD: begin
            v = (a_msb == b_msb) && (r_msb != a_msb);
            c = cout;
         end
         OP_SUB: begin
            v = (a_msb != b_msb) && (r_msb != a_msb);
            c = cout;
         end
         // cmp subtracts A from B, so B is the minuend for overflow.
         OP_CMP: begin
            v = (a_msb != b_msb) && (r_msb != b_msb);
            c = cout;
         end
         OP_ADC: begin
            v = (a == max_pos) & ci;
            c = (a == all_ones) & ci;
         end
         OP_SBC: begin
            v = (a == most_neg) & ci;
            c = (a == 16'h0000) & ci;
         end
         OP_INC: begin
            v    = (a == max_pos);
            mask = 4'b1110;
         end
         OP_DEC: begin
            v    = (a == most_neg);
            mask = 4'b1110;
         end
         OP_INC2, OP_DEC2: begin
            n    = 1'b0;
            z    = 1'b0;
            mask = 4'b0000;
         end
         OP_NEG: begin
            v = (lo == most_neg);
            c = (lo != 16'h0000);
         end
         OP_COM: c = 1'b1;
         OP_ROR, OP_ASR: begin
            c = a[0];
            v = r_msb ^ a[0];
         end
         OP_ROL, OP_ASL: begin
            c = a_msb;
            v = r_msb ^ a_msb;
         end
         OP_MOV, OP_BIT, OP_BIC, OP_BIS, OP_EXOR: mask = 4'b1110;
         OP_SXT: begin
            z    = ~ni;
            mask = 4'b0110;
         end
         // Flags of swab reflect the new low byte only.
         OP_SWAB: begin
            n = lo[7];
            z = (lo[7:0] == 8'h00);
         end
         OP_NONE: begin
            n    = 1'b0;
            z    = 1'b0;
            mask = 4'b0000;
         end
         default: ;
      endcase
      flags        = 4'b0000;
      flags[FLG_N] = n;
      flags[FLG_Z] = z;
      flags[FLG_V] = v;
      flags[FLG_C] = c;
   end

endmodule

// File: rtl/my_alu.sv
// my_alu: PDP-11 / 1801VM1 compatible 16-bit ALU with registered result/flags/mask.
// Latency: 1 cycle, output register loads on every rising edge of clkdbi.
// Backpressure: none; inputs must be stable at the edge, no handshake.
// Ports: clkdbi, reset_n (async, active-low), bus (my_alu_if.slave).
module my_alu
   import my_alu_pkg::*;
(
   input  logic    clkdbi,
   input  logic    reset_n,
   my_alu_if.slave bus
);

   op_strb_t    strb;
   logic [15:0] core_result;
   logic [3:0]  core_flags;
   logic [3:0]  core_mask;
   logic [15:0] result_q;
   logic [3:0]  flags_q;
   logic [3:0]  mask_q;

   assign strb = {bus.add,  bus.adc,  bus.sub,  bus.sbc,
                  bus.inc2, bus.dec2, bus.inc,  bus.dec,
                  bus.clr,  bus.com,  bus.neg,  bus.tst,
                  bus.ror,  bus.rol,  bus.asr,  bus.asl,
                  bus.sxt,  bus.mov,  bus.cmp,  bus.bit_,
                  bus.bic,  bus.bis,  bus.exor, bus.swab};

   alu_core u_core (
      .in1    (bus.in1),
      .in2    (bus.in2),
      .ni     (bus.ni),
      .ci     (bus.ci),
      .mbyte  (bus.mbyte),
      .strb   (strb),
      .result (core_result),
      .flags  (core_flags),
      .mask   (core_mask)
   );

   always_ff @(posedge clkdbi or negedge reset_n) begin
      if (!reset_n) begin
         result_q <= '0;
         flags_q  <= '0;
         mask_q   <= '0;
      end else begin
         result_q <= core_result;
         flags_q  <= core_flags;
         mask_q   <= core_mask;
      end
   end

   assign bus.final_result = result_q;
   assign bus.final_flags  = flags_q;
   assign bus.ccmask       = mask_q;

endmodule

// File: tb/tb_my_alu.sv
// tb_my_alu: directed vectors with hand-computed results for my_alu.
// Latency: expects results one rising edge after inputs are applied.
// Backpressure: none; inputs driven on the falling edge, outputs sampled 1 time unit after the rising edge.
module tb_my_alu;
   import my_alu_pkg::*;

   logic clkdbi;
   logic reset_n;
   int   n_chk;
   int   n_pass;

   my_alu_if bus ();

   my_alu dut (
      .clkdbi  (clkdbi),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clkdbi = 1'b0;
   always #5 clkdbi = ~clkdbi;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic op_strb_t strb_of(input op_e o);
      logic [23:0] v;
      v = 24'h800000;
      if (o == OP_NONE) return op_strb_t'(24'h000000);
      return op_strb_t'(v >> (int'(o) - 1));
   endfunction

   task automatic put(input op_strb_t s, input logic [15:0] a, input logic [15:0] b,
                      input logic m, input logic c_in, input logic n_in);
      bus.in2   = a;
      bus.in1   = b;
      bus.mbyte = m;
      bus.ci    = c_in;
      bus.ni    = n_in;
      {bus.add,  bus.adc,  bus.sub,  bus.sbc,
       bus.inc2, bus.dec2, bus.inc,  bus.dec,
       bus.clr,  bus.com,  bus.neg,  bus.tst,
       bus.ror,  bus.rol,  bus.asr,  bus.asl,
       bus.sxt,  bus.mov,  bus.cmp,  bus.bit_,
       bus.bic,  bus.bis,  bus.exor, bus.swab} = s;
   endtask

   // Apply on the falling edge, sample just after the next rising edge.
   task automatic step(input op_strb_t s, input logic [15:0] a, input logic [15:0] b,
                       input logic m, input logic c_in, input logic n_in);
      @(negedge clkdbi);
      put(s, a, b, m, c_in, n_in);
      @(posedge clkdbi);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      n_chk   = 0;
      n_pass  = 0;
      reset_n = 1'b0;
      // add active during reset: a leaking register would show 0002.
      put(strb_of(OP_ADD), 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      @(posedge clkdbi); @(posedge clkdbi); #1;
      chk("rst_result", bus.final_result, 16'h0000);
      chk("rst_flags", {12'h0, bus.final_flags}, 16'h0000);
      chk("rst_mask", {12'h0, bus.ccmask}, 16'h0000);
      @(negedge clkdbi);
      reset_n = 1'b1;

      step(strb_of(OP_ADD), 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("add_result", bus.final_result, 16'h8000);
      chk("add_flags", {12'h0, bus.final_flags}, 16'h000A);
      chk("add_mask", {12'h0, bus.ccmask}, 16'h000F);

      step(strb_of(OP_SUB), 16'h1200, 16'h0001, 1'b1, 1'b0, 1'b0);
      chk("subb_result", bus.final_result, 16'h12FF);
      chk("subb_flags", {12'h0, bus.final_flags}, 16'h0009);

      step(strb_of(OP_ROR), 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("ror_result", bus.final_result, 16'h8000);
      chk("ror_flags", {12'h0, bus.final_flags}, 16'h0009);

      step(strb_of(OP_ASL), 16'h4000, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("asl_result", bus.final_result, 16'h8000);
      chk("asl_flags", {12'h0, bus.final_flags}, 16'h000A);

      // inc2 stays a word op even with mbyte set.
      step(strb_of(OP_INC2), 16'h10FF, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk("inc2_result", bus.final_result, 16'h1101);
      chk("inc2_mask", {12'h0, bus.ccmask}, 16'h0000);
      chk("inc2_flags", {12'h0, bus.final_flags}, 16'h0000);

      step(strb_of(OP_INC), 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("inc_result", bus.final_result, 16'h8000);
      chk("inc_nzv", {13'h0, bus.final_flags[3:1]}, 16'h0005);
      chk("inc_mask", {12'h0, bus.ccmask}, 16'h000E);

      step(strb_of(OP_SWAB), 16'h00AB, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("swab_result", bus.final_result, 16'hAB00);
      chk("swab_flags", {12'h0, bus.final_flags}, 16'h0004);

      step(strb_of(OP_SXT), 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1);
      chk("sxt_result", bus.final_result, 16'hFFFF);
      chk("sxt_mask", {12'h0, bus.ccmask}, 16'h0006);
      chk("sxt_zv", {14'h0, bus.final_flags[2:1]}, 16'h0000);

      step(strb_of(OP_CMP), 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0);
      chk("cmp_result", bus.final_result, 16'hFFFE);
      chk("cmp_flags", {12'h0, bus.final_flags}, 16'h0009);

      step(strb_of(OP_ADC), 16'h12FF, 16'h0000, 1'b1, 1'b1, 1'b0);
      chk("adcb_result", bus.final_result, 16'h1200);
      chk("adcb_flags", {12'h0, bus.final_flags}, 16'h0005);

      step(strb_of(OP_NEG), 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("neg_result", bus.final_result, 16'h8000);
      chk("neg_flags", {12'h0, bus.final_flags}, 16'h000B);

      step(strb_of(OP_BIC), 16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0);
      chk("bic_result", bus.final_result, 16'h00F0);
      chk("bic_nzv", {13'h0, bus.final_flags[3:1]}, 16'h0000);
      chk("bic_mask", {12'h0, bus.ccmask}, 16'h000E);

      step(strb_of(OP_SBC), 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      chk("sbc_result", bus.final_result, 16'hFFFF);
      chk("sbc_flags", {12'h0, bus.final_flags}, 16'h0009);

      step(strb_of(OP_COM), 16'h5500, 16'h0000, 1'b1, 1'b0, 1'b0);
      chk("comb_result", bus.final_result, 16'h55FF);
      chk("comb_flags", {12'h0, bus.final_flags}, 16'h0009);

      step(strb_of(OP_NONE), 16'h1234, 16'h5678, 1'b1, 1'b1, 1'b1);
      chk("none_result", bus.final_result, 16'h0000);
      chk("none_flags", {12'h0, bus.final_flags}, 16'h0000);
      chk("none_mask", {12'h0, bus.ccmask}, 16'h0000);

      // add and sub together: add must win.
      step(strb_of(OP_ADD) | strb_of(OP_SUB), 16'h0003, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("prio_result", bus.final_result, 16'h0004);

      // Asynchronous reset in the middle of a cycle with add active.
      step(strb_of(OP_ADD), 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_result", bus.final_result, 16'h0002);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_result", bus.final_result, 16'h0000);
      chk("arst_mask", {12'h0, bus.ccmask}, 16'h0000);
      @(posedge clkdbi); #1;
      chk("arst_hold", bus.final_result, 16'h0000);
      @(negedge clkdbi);
      reset_n = 1'b1;
      #1;
      chk("rel_before_edge", bus.final_result, 16'h0000);
      @(posedge clkdbi); #1;
      chk("rel_after_edge", bus.final_result, 16'h0002);
      chk("rel_mask", {12'h0, bus.ccmask}, 16'h000F);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/my_alu.md
# my_alu

PDP-11 / 1801VM1-compatible 16-bit ALU for the soft-CPU datapath. It executes one of 24 one-hot operation strobes on two operands, in word or byte mode. It produces a result, new N/Z/V/C flag values and a mask of which flags the operation updates. Results and flags are registered on `clkdbi` and consumed by the datapath's register, PSW and condition-code logic.

## Interface
- No parameters; data width fixed at 16 bits.
- clkdbi  in  1  clock; outputs update on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in1  in  16  operand B (source / offset operand).
- in2  in  16  operand A (primary / destination operand; sole operand of unary ops).
- ni  in  1  current PSW N flag (used by sxt).
- ci  in  1  current PSW C flag (used by adc, sbc, ror, rol).
- mbyte  in  1  byte mode: operate on bits [7:0].
- add, adc, sub, sbc, inc2, dec2, inc, dec, clr, com, neg, tst, ror, rol, asr, asl, sxt, mov, cmp, bit_, bic, bis, exor, swab  in  1 each  operation strobes, one-hot.
- final_result  out  16  registered result.
- final_flags  out  4  registered {N,Z,V,C}.
- ccmask  out  4  registered {N,Z,V,C} update mask; 1 = PSW bit takes the final_flags value.

## Operation
- Width: w = 8 when mbyte = 1, else 16. Byte ops write result[7:0] and pass in2[15:8] to result[15:8]. The msb for N/V/C is bit w−1; Z tests bits [w−1:0]. Exception: inc2, dec2 and swab are always word operations.
- add: A+B; C = carry out of msb; V = A,B same sign and result sign differs. Mask 1111.
- sub: A−B. cmp: B−A, result not architecturally stored but still output. For both, C = borrow; V = operands differ in sign and result sign ≠ minuend sign. Mask 1111.
- adc: A+ci; V = (A == max positive) & ci; C = (A == all ones) & ci. Mask 1111.
- sbc: A−ci; V = (A == most negative) & ci; C = (A == 0) & ci. Mask 1111.
- inc: A+1; V = (A == max positive). dec: A−1; V = (A == most negative). Mask 1110; C not touched.
- inc2: A+2. dec2: A−2. Both word only; mask 0000; final_flags = 0.
- neg: 0−A; V = (result == most negative); C = (result ≠ 0). Mask 1111.
- tst: A; V = 0, C = 0. com: ~A; V = 0, C = 1. clr: 0; flags 0100. All mask 1111.
- ror: {ci, A[msb:1]}, C = A[0]. rol: {A[msb−1:0], ci}, C = A[msb].
- asr: {A[msb], A[msb:1]}, C = A[0]. asl: {A[msb−1:0], 0}, C = A[msb].
- For all four shifts: V = N xor C (post-operation values); mask 1111.
- mov: A. bit_: A & B. bic: A & ~B. bis: A | B. exor: A ^ B. All five: V = 0, mask 1110.
- sxt: result = ni ? 16'hFFFF : 0; Z = ~ni; V = 0; mask 0110.
- swab: {A[7:0], A[15:8]}; N = result[7]; Z = (result[7:0] == 0); V = 0; C = 0; mask 1111.
- N = result[msb] and Z = (result == 0) for every op not overridden above.
- No strobe asserted: result 0, flags 0000, mask 0000.
- Several strobes asserted: the first in port-list order wins (add highest, swab lowest).

## Timing
- Combinational core feeds an output register clocked on the rising edge of clkdbi; latency is 1 cycle.
- The register loads every cycle; there is no enable.
- While reset_n = 0, final_result, final_flags and ccmask are all zero. Deassertion takes effect at the next edge.
- Inputs must be stable before the clock edge. There is no handshake.

## Structure
- Shared package: operation-select encoding, most-negative (16'h8000) / max-positive (16'h7FFF) constants and their byte equivalents, and the flag bit indices N=3, Z=2, V=1, C=0.
- Sub-module alu_core holds the purely combinational function (operands, strobes → result/flags/mask). The top level adds only the reset-able output register.

## Test plan
- add, in2 = 16'h7FFF, in1 = 1, word → next cycle result 16'h8000, flags N1 Z0 V1 C0, mask 1111.
- sub, mbyte = 1, in2 = 16'h1200, in1 = 16'h0001 → result 16'h12FF, flags N1 Z0 V0 C1.
- ror, ci = 1, in2 = 16'h0001 → result 16'h8000, flags N1 Z0 V0 C1; then asl, in2 = 16'h4000 → result 16'h8000, flags N1 Z0 V1 C0.
- inc2, in2 = 16'h1000 → result 16'h1002, mask 0000; inc, in2 = 16'h7FFF → result 16'h8000, V1, mask 1110.
- swab, in2 = 16'h00AB → result 16'hAB00, flags N0 Z1 V0 C0; sxt with ni = 1 → result 16'hFFFF, mask 0110, Z0.
- Assert reset_n low mid-stream with add active → all outputs 0 immediately and held 0 until the first edge after release.
